// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and halt drain,
// with saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ID_Valid,
  input  logic [4:0]  ID_RSAddr,
  input  logic [4:0]  ID_RTAddr,
  input  logic        ID_UsesRT,
  input  logic        ID_Halt,
  input  logic        EX_RegWriteEN,
  input  logic        EX_Mem2RegSEL,
  input  logic [4:0]  EX_DstAddr,
  input  logic        EX_BranchTaken,
  output logic        PC_WriteEN,
  output logic        IFID_WriteEN,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        Halted,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;
  logic        lu;

  assign lu = EX_Mem2RegSEL & EX_RegWriteEN & (EX_DstAddr != 5'd0) & ID_Valid &
              ((EX_DstAddr == ID_RSAddr) | (ID_UsesRT & (EX_DstAddr == ID_RTAddr)));

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    stall_d      = stall_q;
    flush_d      = flush_q;
    PC_WriteEN   = 1'b1;
    IFID_WriteEN = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    case (state_q)
      RUN: begin
        if (EX_BranchTaken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          flush_d     = (flush_q == '1) ? flush_q : flush_q + 16'd1;
        end else if (lu) begin
          // A halt sitting behind a load-use stall is retried next cycle.
          PC_WriteEN   = 1'b0;
          IFID_WriteEN = 1'b0;
          IDEX_Bubble  = 1'b1;
          stall_d      = (stall_q == '1) ? stall_q : stall_q + 16'd1;
        end else if (ID_Valid && ID_Halt) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      DRAIN, HALTED: begin
        PC_WriteEN   = 1'b0;
        IFID_WriteEN = 1'b0;
        IFID_Flush   = 1'b1;
        IDEX_Bubble  = 1'b1;
        if (state_q == DRAIN) begin
          if (drain_q == 4'd0) state_d = HALTED;
          else                 drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign Halted     = (state_q == HALTED);
  assign StallCount = stall_q;
  assign FlushCount = flush_q;

endmodule
